// File: rtl/wb_stage_pipe_if.sv
// rtl/wb_stage_pipe_if.sv - MEM-to-WB bundle: MEM-stage capture inputs, stall/flush and regfile write port.
interface wb_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              m_valid;
  logic [DATA_W-1:0] m_r_alu;
  logic [DATA_W-1:0] m_m_o;
  logic              m_m2reg;
  logic              m_wreg;
  logic [REG_AW-1:0] m_rn;
  logic [1:0]        m_ldsize;
  logic              m_ldsign;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] wdi;
  logic              wwreg;
  logic [REG_AW-1:0] wrn;
  logic              w_valid;
  logic [CNT_W-1:0]  retired;

  modport master (
    output m_valid, m_r_alu, m_m_o, m_m2reg, m_wreg, m_rn, m_ldsize, m_ldsign, stall, flush,
    input  wdi, wwreg, wrn, w_valid, retired
  );

  modport slave (
    input  m_valid, m_r_alu, m_m_o, m_m2reg, m_wreg, m_rn, m_ldsize, m_ldsign, stall, flush,
    output wdi, wwreg, wrn, w_valid, retired
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - MEM/WB pipeline register with result select; WB_LOAD_EXT_EN enables sub-word load extension.
module wb_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic           clk,
  input logic           clrn,
  wb_stage_pipe_if.slave bus
);

  logic              w_valid_q, w_valid_d;
  logic              w_wreg_q,  w_wreg_d;
  logic              w_m2reg_q, w_m2reg_d;
  logic [REG_AW-1:0] w_rn_q,    w_rn_d;
  logic [DATA_W-1:0] w_r_alu_q, w_r_alu_d;
  logic [DATA_W-1:0] w_m_o_q,   w_m_o_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] ext_data;

`ifdef WB_LOAD_EXT_EN
  logic [1:0] w_ldsize_q, w_ldsize_d;
  logic       w_ldsign_q, w_ldsign_d;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
`else
  logic unused_ld;
  assign unused_ld = ^{bus.m_ldsize, bus.m_ldsign};
`endif

  always_comb begin
    w_valid_d = w_valid_q;
    w_wreg_d  = w_wreg_q;
    w_m2reg_d = w_m2reg_q;
    w_rn_d    = w_rn_q;
    w_r_alu_d = w_r_alu_q;
    w_m_o_d   = w_m_o_q;
    retired_d = retired_q;
`ifdef WB_LOAD_EXT_EN
    w_ldsize_d = w_ldsize_q;
    w_ldsign_d = w_ldsign_q;
`endif
    // An instruction retires on the edge it leaves WB; a flush also evicts a stalled one.
    if (w_valid_q && (!bus.stall || bus.flush)) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (bus.flush) begin
      w_valid_d = 1'b0;
      w_wreg_d  = 1'b0;
    end else if (!bus.stall) begin
      w_valid_d = bus.m_valid;
      w_wreg_d  = bus.m_wreg & bus.m_valid;
      w_m2reg_d = bus.m_m2reg;
      w_rn_d    = bus.m_rn;
      w_r_alu_d = bus.m_r_alu;
      w_m_o_d   = bus.m_m_o;
`ifdef WB_LOAD_EXT_EN
      w_ldsize_d = bus.m_ldsize;
      w_ldsign_d = bus.m_ldsign;
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_valid_q <= 1'b0;
      w_wreg_q  <= 1'b0;
      w_m2reg_q <= 1'b0;
      w_rn_q    <= '0;
      w_r_alu_q <= '0;
      w_m_o_q   <= '0;
      retired_q <= '0;
`ifdef WB_LOAD_EXT_EN
      w_ldsize_q <= 2'b00;
      w_ldsign_q <= 1'b0;
`endif
    end else begin
      w_valid_q <= w_valid_d;
      w_wreg_q  <= w_wreg_d;
      w_m2reg_q <= w_m2reg_d;
      w_rn_q    <= w_rn_d;
      w_r_alu_q <= w_r_alu_d;
      w_m_o_q   <= w_m_o_d;
      retired_q <= retired_d;
`ifdef WB_LOAD_EXT_EN
      w_ldsize_q <= w_ldsize_d;
      w_ldsign_q <= w_ldsign_d;
`endif
    end
  end

`ifdef WB_LOAD_EXT_EN
  always_comb begin
    case (w_r_alu_q[1:0])
      2'd0:    byte_lane = w_m_o_q[7:0];
      2'd1:    byte_lane = w_m_o_q[15:8];
      2'd2:    byte_lane = w_m_o_q[23:16];
      default: byte_lane = w_m_o_q[31:24];
    endcase
    half_lane = w_r_alu_q[1] ? w_m_o_q[31:16] : w_m_o_q[15:0];
    case (w_ldsize_q)
      2'b01:   ext_data = {{(DATA_W-8){w_ldsign_q & byte_lane[7]}}, byte_lane};
      2'b10:   ext_data = {{(DATA_W-16){w_ldsign_q & half_lane[15]}}, half_lane};
      default: ext_data = w_m_o_q;
    endcase
  end
`else
  assign ext_data = w_m_o_q;
`endif

  assign bus.wdi     = w_valid_q ? (w_m2reg_q ? ext_data : w_r_alu_q) : '0;
  assign bus.wwreg   = w_valid_q & w_wreg_q & (w_rn_q != '0);
  assign bus.wrn     = w_rn_q;
  assign bus.w_valid = w_valid_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - Self-checking bench for wb_stage_pipe with a behavioural write-back model.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        m_valid, m_m2reg, m_wreg, m_ldsign, stall, flush;
  logic [31:0] m_r_alu, m_m_o;
  logic [4:0]  m_rn;
  logic [1:0]  m_ldsize;

  int checks = 0;
  int failures = 0;

  // Reference state: what WB holds, stored as the final write value rather than raw fields.
  logic        e_valid, e_wreg;
  logic [4:0]  e_rn;
  logic [31:0] e_data;
  longint      e_retired;

  wb_stage_pipe_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) ifa ();
  wb_stage_pipe_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  ifb ();

  assign ifa.m_valid = m_valid;   assign ifb.m_valid = m_valid;
  assign ifa.m_r_alu = m_r_alu;   assign ifb.m_r_alu = m_r_alu;
  assign ifa.m_m_o = m_m_o;       assign ifb.m_m_o = m_m_o;
  assign ifa.m_m2reg = m_m2reg;   assign ifb.m_m2reg = m_m2reg;
  assign ifa.m_wreg = m_wreg;     assign ifb.m_wreg = m_wreg;
  assign ifa.m_rn = m_rn;         assign ifb.m_rn = m_rn;
  assign ifa.m_ldsize = m_ldsize; assign ifb.m_ldsize = m_ldsize;
  assign ifa.m_ldsign = m_ldsign; assign ifb.m_ldsign = m_ldsign;
  assign ifa.stall = stall;       assign ifb.stall = stall;
  assign ifa.flush = flush;       assign ifb.flush = flush;

  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut_a (.clk(clk), .clrn(clrn), .bus(ifa.slave));
  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dut_b (.clk(clk), .clrn(clrn), .bus(ifb.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(logic [31:0] alu, logic [31:0] mo, logic m2reg,
                                               logic [1:0] ldsize, logic ldsign);
    logic [31:0] lane;
    if (!m2reg) return alu;
`ifdef WB_LOAD_EXT_EN
    if (ldsize == 2'b01) begin
      lane = (mo >> (8 * alu[1:0])) & 32'hFF;
      if (ldsign && lane >= 32'd128) lane = lane + 32'hFFFF_FF00;
      return lane;
    end
    if (ldsize == 2'b10) begin
      lane = (mo >> (16 * alu[1])) & 32'hFFFF;
      if (ldsign && lane >= 32'h8000) lane = lane + 32'hFFFF_0000;
      return lane;
    end
`endif
    return mo;
  endfunction

  function automatic void model_reset();
    e_valid = 1'b0; e_wreg = 1'b0; e_rn = '0; e_data = '0; e_retired = 0;
  endfunction

  task automatic drive_idle();
    m_valid = 0; m_r_alu = '0; m_m_o = '0; m_m2reg = 0; m_wreg = 0;
    m_rn = '0; m_ldsize = '0; m_ldsign = 0; stall = 0; flush = 0;
  endtask

  task automatic drive_random();
    m_valid = 1'($urandom); m_r_alu = $urandom; m_m_o = $urandom; m_m2reg = 1'($urandom);
    m_wreg = 1'($urandom); m_rn = 5'($urandom); m_ldsize = 2'($urandom); m_ldsign = 1'($urandom);
  endtask

  // One clock edge: advance the model with the inputs the DUT just sampled, then settle.
  task automatic tick();
    @(posedge clk);
    if (clrn) begin
      if (e_valid && (!stall || flush)) e_retired++;
      if (flush) begin
        e_valid = 0; e_wreg = 0;
      end else if (!stall) begin
        e_valid = m_valid;
        e_wreg  = m_wreg && m_valid;
        e_rn    = m_rn;
        e_data  = model_result(m_r_alu, m_m_o, m_m2reg, m_ldsize, m_ldsign);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    clrn = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_random(); stall = 1'($urandom); flush = 1'($urandom);
      tick();
      checks++;
      if (ifa.wwreg !== 1'b0 || ifa.w_valid !== 1'b0 || ifa.wdi !== 32'h0 || ifa.retired !== 32'h0 || ifa.wrn !== 5'h0) begin
        failures++;
        $display("FAIL reset: wwreg=%b w_valid=%b wdi=%h retired=%0d wrn=%0d required all zero",
                 ifa.wwreg, ifa.w_valid, ifa.wdi, ifa.retired, ifa.wrn);
      end
    end
    drive_idle();
    @(negedge clk);
    clrn = 1;
    #1;
  endtask

  task automatic test_alu_writeback();
    longint r0;
    drive_idle();
    m_valid = 1; m_wreg = 1; m_m2reg = 0; m_r_alu = 32'h1234_5678; m_rn = 5'd7; m_m_o = $urandom;
    r0 = e_retired;
    tick();
    checks++;
    if (ifa.wdi !== 32'h1234_5678 || ifa.wrn !== 5'd7 || ifa.wwreg !== 1'b1) begin
      failures++;
      $display("FAIL alu_wb: wdi=%h wrn=%0d wwreg=%b required 12345678/7/1", ifa.wdi, ifa.wrn, ifa.wwreg);
    end
    drive_idle();
    tick();
    checks++;
    if (ifa.retired !== 32'(r0 + 1)) begin
      failures++;
      $display("FAIL alu_retire: retired=%0d required %0d", ifa.retired, r0 + 1);
    end
  endtask

  task automatic test_r0_guard();
    longint r0;
    drive_idle();
    m_valid = 1; m_wreg = 1; m_r_alu = 32'h1234_5678; m_rn = 5'd0;
    r0 = e_retired;
    tick();
    checks++;
    if (ifa.wwreg !== 1'b0 || ifa.w_valid !== 1'b1) begin
      failures++;
      $display("FAIL r0_guard: wwreg=%b w_valid=%b required 0/1", ifa.wwreg, ifa.w_valid);
    end
    drive_idle();
    tick();
    checks++;
    if (ifa.retired !== 32'(r0 + 1)) begin
      failures++;
      $display("FAIL r0_retire: retired=%0d required %0d", ifa.retired, r0 + 1);
    end
  endtask

  task automatic test_stall_flush();
    longint r0;
    drive_idle();
    m_valid = 1; m_wreg = 1; m_rn = 5'd3; m_r_alu = 32'hCAFE_0003;
    tick();
    r0 = e_retired;
    for (int i = 0; i < 2; i++) begin
      drive_random(); m_valid = 1; m_rn = 5'd9; stall = 1;
      tick();
      checks++;
      if (ifa.wrn !== 5'd3 || ifa.wdi !== 32'hCAFE_0003 || ifa.wwreg !== 1'b1 || ifa.retired !== 32'(r0)) begin
        failures++;
        $display("FAIL stall_hold: wrn=%0d wdi=%h wwreg=%b retired=%0d required 3/cafe0003/1/%0d",
                 ifa.wrn, ifa.wdi, ifa.wwreg, ifa.retired, r0);
      end
    end
    stall = 1; flush = 1;
    tick();
    checks++;
    if (ifa.w_valid !== 1'b0 || ifa.wwreg !== 1'b0 || ifa.wdi !== 32'h0 || ifa.retired !== 32'(r0 + 1)) begin
      failures++;
      $display("FAIL stall_flush: w_valid=%b wwreg=%b wdi=%h retired=%0d required 0/0/0/%0d",
               ifa.w_valid, ifa.wwreg, ifa.wdi, ifa.retired, r0 + 1);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_subword();
    logic [1:0]  sz [3] = '{2'b01, 2'b01, 2'b10};
    logic        sg [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] exp_v [3];
`ifdef WB_LOAD_EXT_EN
    exp_v = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF};
`else
    exp_v = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      m_valid = 1; m_wreg = 1; m_m2reg = 1; m_rn = 5'd12;
      m_m_o = 32'h80FF_7F01; m_r_alu = 32'h0000_1002; m_ldsize = sz[i]; m_ldsign = sg[i];
      tick();
      checks++;
      if (ifa.wdi !== exp_v[i]) begin
        failures++;
        $display("FAIL subword[%0d]: wdi=%h required %h", i, ifa.wdi, exp_v[i]);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive_random();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (ifa.w_valid !== e_valid || ifa.wrn !== e_rn ||
          ifa.wdi !== (e_valid ? e_data : 32'h0) ||
          ifa.wwreg !== (e_valid && e_wreg && e_rn != 0) ||
          ifa.retired !== 32'(e_retired)) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL random[%0d]: v=%b rn=%0d wdi=%h we=%b ret=%0d required v=%b rn=%0d wdi=%h we=%b ret=%0d",
                   i, ifa.w_valid, ifa.wrn, ifa.wdi, ifa.wwreg, ifa.retired, e_valid, e_rn,
                   e_valid ? e_data : 32'h0, e_valid && e_wreg && e_rn != 0, 32'(e_retired));
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_wrap();
    @(negedge clk); clrn = 0; model_reset();
    @(negedge clk); clrn = 1; #1;
    for (int i = 0; i < 17; i++) begin
      drive_idle(); m_valid = 1; m_wreg = 1; m_rn = 5'(i + 1); m_r_alu = $urandom;
      tick();
    end
    drive_idle();
    tick();
    checks++;
    if (ifb.retired !== 4'd1 || ifa.retired !== 32'd17) begin
      failures++;
      $display("FAIL wrap: small=%0d big=%0d required 1/17", ifb.retired, ifa.retired);
    end
    for (int i = 0; i < 3; i++) begin
      m_valid = 1; m_wreg = 1; m_rn = 5'd5;
      tick();
    end
    #2;
    clrn = 0;
    #1;
    model_reset();
    checks++;
    if (ifa.retired !== 32'h0 || ifb.retired !== 4'h0 || ifa.w_valid !== 1'b0 || ifa.wwreg !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: big=%0d small=%0d w_valid=%b wwreg=%b required all zero",
               ifa.retired, ifb.retired, ifa.w_valid, ifa.wwreg);
    end
    @(negedge clk); clrn = 1;
    drive_idle(); m_valid = 1; m_wreg = 1; m_rn = 5'd4; m_r_alu = 32'h0BAD_F00D;
    tick();
    checks++;
    if (ifa.wdi !== 32'h0BAD_F00D || ifa.wwreg !== 1'b1 || ifa.retired !== 32'h0) begin
      failures++;
      $display("FAIL post_release: wdi=%h wwreg=%b retired=%0d required 0badf00d/1/0",
               ifa.wdi, ifa.wwreg, ifa.retired);
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_alu_writeback();
    test_r0_guard();
    test_stall_flush();
    test_subword();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
